// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch -- instruction fetch stage feeding decode.
//
// Issues one group-aligned read per cycle to instruction memory while credits
// remain (in-flight requests plus buffered groups below BUFFER_DEPTH), tracks
// outstanding requests in a MEM_LATENCY-deep shift register, captures returned
// groups into a small FIFO and offers the FIFO head to decode over valid/ready.
// A redirect flushes the FIFO and all in-flight requests and restarts fetch at
// the new PC on the following cycle.
//
// Ports:
//   clk_in                  clock
//   rst_in                  asynchronous, active-high reset
//   redirect_valid_in       redirect request this cycle
//   redirect_pc_in   [31:0] new word-address PC (group aligned)
//   imem_req_out            read request this cycle
//   imem_addr_out    [31:0] word address of the requested group
//   imem_data_in            group data, MEM_LATENCY cycles after its request
//   decode_ready_in         decode can accept a group
//   decode_valid_out        group available
//   decode_data_out         instruction words, element i is at PC+i
//   decode_pc_out    [31:0] PC of element 0
//
// Optional build macro FETCH_PERF_COUNTERS_EN adds:
//   groups_delivered_out    [31:0] count of decode handshakes
//   backpressure_cycles_out [31:0] count of cycles with valid && !ready
// -----------------------------------------------------------------------------

// Flags a write into a full FIFO that is not matched by a pop in the same cycle.
module fetch_checker (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic full
);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
    else $error("fetch: push into full FIFO");
endmodule

module fetch #(
  parameter int          SUPER_SCALAR_WIDTH = 2,
  parameter logic [31:0] RESET_PC           = 32'h0,
  parameter int          MEM_LATENCY        = 2,
  parameter int          BUFFER_DEPTH       = 4
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                redirect_valid_in,
  input  logic [31:0]                         redirect_pc_in,
  output logic                                imem_req_out,
  output logic [31:0]                         imem_addr_out,
  input  logic [SUPER_SCALAR_WIDTH-1:0][31:0] imem_data_in,
  input  logic                                decode_ready_in,
  output logic                                decode_valid_out,
  output logic [SUPER_SCALAR_WIDTH-1:0][31:0] decode_data_out,
  output logic [31:0]                         decode_pc_out
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]                         groups_delivered_out,
  output logic [31:0]                         backpressure_cycles_out
`endif
);

  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [SUPER_SCALAR_WIDTH-1:0][31:0] group_t;

  localparam group_t            GROUP_ZERO = {(SUPER_SCALAR_WIDTH*32){1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(BUFFER_DEPTH);

  logic [31:0]            pc_r;
  logic [MEM_LATENCY-1:0] pipe_valid_r;
  logic [31:0]            pipe_pc_r [MEM_LATENCY];
  group_t                 fifo_data_r [BUFFER_DEPTH];
  logic [31:0]            fifo_pc_r [BUFFER_DEPTH];
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [CNT_W-1:0]       count_r;

  logic [31:0]            in_flight_s;
  logic                   req_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   hs_s;
  logic                   valid_s;
  logic                   full_s;

  // Number of requests still travelling through the memory pipe.
  always_comb begin
    in_flight_s = 32'd0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      in_flight_s = in_flight_s + 32'(pipe_valid_r[i]);
    end
  end

  // Issue, capture and handshake decisions; a redirect suppresses all of them.
  always_comb begin
    valid_s = (count_r != {CNT_W{1'b0}});
    full_s  = (count_r == CNT_FULL);
    req_s   = !rst_in && !redirect_valid_in &&
              ((in_flight_s + 32'(count_r)) < 32'(BUFFER_DEPTH));
    push_s  = pipe_valid_r[MEM_LATENCY-1] && !redirect_valid_in;
    hs_s    = valid_s && decode_ready_in;
    pop_s   = hs_s && !redirect_valid_in;
  end

  // Fetch PC: reloaded on redirect, advanced by one group per issued request.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc_r <= RESET_PC;
    end else if (redirect_valid_in) begin
      pc_r <= redirect_pc_in;
    end else if (req_s) begin
      pc_r <= pc_r + 32'(SUPER_SCALAR_WIDTH);
    end else begin
      pc_r <= pc_r;
    end
  end

  // In-flight shift register; a redirect kills every outstanding request.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pipe_valid_r <= {MEM_LATENCY{1'b0}};
      for (int i = 0; i < MEM_LATENCY; i++) begin
        pipe_pc_r[i] <= 32'h0;
      end
    end else begin
      pipe_pc_r[0] <= pc_r;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_pc_r[i] <= pipe_pc_r[i-1];
      end
      if (redirect_valid_in) begin
        pipe_valid_r <= {MEM_LATENCY{1'b0}};
      end else begin
        pipe_valid_r[0] <= req_s;
        for (int i = 1; i < MEM_LATENCY; i++) begin
          pipe_valid_r[i] <= pipe_valid_r[i-1];
        end
      end
    end
  end

  // Fetch-group FIFO: captures returning memory data, emptied on redirect.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        fifo_data_r[i] <= GROUP_ZERO;
        fifo_pc_r[i]   <= 32'h0;
      end
    end else if (redirect_valid_in) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= imem_data_in;
        fifo_pc_r[wr_ptr_r]   <= pipe_pc_r[MEM_LATENCY-1];
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Decode outputs come straight from FIFO registers; zero when nothing is held.
  always_comb begin
    decode_valid_out = valid_s;
    if (valid_s) begin
      decode_data_out = fifo_data_r[rd_ptr_r];
      decode_pc_out   = fifo_pc_r[rd_ptr_r];
    end else begin
      decode_data_out = GROUP_ZERO;
      decode_pc_out   = 32'h0;
    end
  end

  assign imem_req_out  = req_s;
  assign imem_addr_out = pc_r;

  fetch_checker u_checker (
    .clk  (clk_in),
    .rst  (rst_in),
    .push (push_s),
    .pop  (pop_s),
    .full (full_s)
  );

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] groups_r;
  logic [31:0] backpressure_r;

  // Free-running statistics; only reset clears them, redirects do not.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      groups_r       <= 32'h0;
      backpressure_r <= 32'h0;
    end else begin
      if (hs_s) begin
        groups_r <= groups_r + 32'd1;
      end
      if (valid_s && !decode_ready_in) begin
        backpressure_r <= backpressure_r + 32'd1;
      end
    end
  end

  assign groups_delivered_out    = groups_r;
  assign backpressure_cycles_out = backpressure_r;
`endif

endmodule

// File: tb/tb_fetch.sv
// -----------------------------------------------------------------------------
// tb_fetch -- scoreboard bench for the fetch stage.
// The stimulus process drives reset, redirects and decode_ready; whenever the
// fetch stream (re)starts it loads the scoreboard with the groups decode must
// see, in order. A memory model answers each request exactly MEM_LATENCY
// cycles later with address-derived words (random junk otherwise). A monitor
// checks request issue, valid timing and every presented group each cycle.
// -----------------------------------------------------------------------------
module tb_fetch;
  localparam int          SSW          = 2;
  localparam int          MEM_LATENCY  = 2;
  localparam int          BUFFER_DEPTH = 4;
  localparam logic [31:0] RESET_PC     = 32'h0;

  typedef logic [SSW-1:0][31:0] group_t;
  typedef struct packed {
    logic [31:0] pc;
    group_t      data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  group_t      imem_data;
  logic        decode_ready;
  logic        decode_valid;
  group_t      decode_data;
  logic [31:0] decode_pc;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] groups_delivered;
  logic [31:0] backpressure_cycles;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 10;

  exp_t sb_q[$];
  int   out_q[$];
  logic [31:0] next_pc = RESET_PC;
  logic [31:0] hs_cnt = 32'h0;
  logic [31:0] bp_cnt = 32'h0;

  logic        hist_v [8] = '{default: 1'b0};
  logic [31:0] hist_a [8] = '{default: 32'h0};

  fetch #(
    .SUPER_SCALAR_WIDTH (SSW),
    .RESET_PC           (RESET_PC),
    .MEM_LATENCY        (MEM_LATENCY),
    .BUFFER_DEPTH       (BUFFER_DEPTH)
  ) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .redirect_valid_in (redirect_valid),
    .redirect_pc_in    (redirect_pc),
    .imem_req_out      (imem_req),
    .imem_addr_out     (imem_addr),
    .imem_data_in      (imem_data),
    .decode_ready_in   (decode_ready),
    .decode_valid_out  (decode_valid),
    .decode_data_out   (decode_data),
    .decode_pc_out     (decode_pc)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .groups_delivered_out    (groups_delivered),
    .backpressure_cycles_out (backpressure_cycles)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic group_t mkgrp(input logic [31:0] a);
    group_t g;
    for (int i = 0; i < SSW; i++) g[i] = word_of(a + 32'(i));
    return g;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected decode stream after the fetch PC is (re)started at base.
  task automatic flush_expect(input logic [31:0] base);
    exp_t e;
    sb_q.delete();
    for (int n = 0; n < 600; n++) begin
      e.pc   = base + 32'(n * SSW);
      e.data = mkgrp(e.pc);
      sb_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    flush_expect(RESET_PC);
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
    flush_expect(target);
  endtask

  // Memory model: answer each request exactly MEM_LATENCY cycles later.
  always @(negedge clk) begin
    int idx;
    int old;
    idx = cyc % 8;
    old = (cyc - MEM_LATENCY) % 8;
    hist_v[idx] = imem_req;
    hist_a[idx] = imem_addr;
    if (hist_v[old]) imem_data = mkgrp(hist_a[old]);
    else             imem_data = {$urandom, $urandom};
  end

  // Monitor: request/valid protocol model plus scoreboard of delivered groups.
  always @(negedge clk) begin
    logic exp_req;
    logic exp_valid;
    if (rst) begin
      chk("rst_req",   {63'h0, imem_req},     64'h0);
      chk("rst_valid", {63'h0, decode_valid}, 64'h0);
      chk("rst_pc",    {32'h0, decode_pc},    64'h0);
      chk("rst_data",  decode_data,           64'h0);
`ifdef FETCH_PERF_COUNTERS_EN
      chk("rst_groups", {32'h0, groups_delivered},    64'h0);
      chk("rst_bp",     {32'h0, backpressure_cycles}, 64'h0);
`endif
      out_q.delete();
      next_pc = RESET_PC;
      hs_cnt  = 32'h0;
      bp_cnt  = 32'h0;
    end else begin
      exp_req = !redirect_valid && (out_q.size() < BUFFER_DEPTH);
      chk("req", {63'h0, imem_req}, {63'h0, exp_req});
      if (exp_req) chk("req_addr", {32'h0, imem_addr}, {32'h0, next_pc});
      exp_valid = (out_q.size() > 0) && ((cyc - out_q[0]) >= MEM_LATENCY + 1);
      chk("valid", {63'h0, decode_valid}, {63'h0, exp_valid});
`ifdef FETCH_PERF_COUNTERS_EN
      chk("groups_delivered",    {32'h0, groups_delivered},    {32'h0, hs_cnt});
      chk("backpressure_cycles", {32'h0, backpressure_cycles}, {32'h0, bp_cnt});
`endif
      if (exp_valid) begin
        if (sb_q.size() == 0) begin
          chk("sb_nonempty", 64'h0, 64'h1);
        end else begin
          chk("dec_pc",   {32'h0, decode_pc}, {32'h0, sb_q[0].pc});
          chk("dec_data", decode_data,        sb_q[0].data);
          if (decode_ready) void'(sb_q.pop_front());
        end
        if (decode_ready) begin
          void'(out_q.pop_front());
          hs_cnt = hs_cnt + 32'd1;
        end else begin
          bp_cnt = bp_cnt + 32'd1;
        end
      end
      if (redirect_valid) begin
        out_q.delete();
        next_pc = redirect_pc;
      end else if (exp_req) begin
        out_q.push_back(cyc);
        next_pc = next_pc + 32'(SSW);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    decode_ready   = 1'b0;
    imem_data      = {(SSW*32){1'b0}};
    repeat (3) step();
    flush_expect(RESET_PC);
    rst = 1'b0;

    // Free-flowing fetch from reset.
    decode_ready = 1'b1;
    repeat (20) step();

    // Backpressure from reset, then drain.
    do_reset();
    decode_ready = 1'b0;
    repeat (10) step();
    decode_ready = 1'b1;
    repeat (12) step();

    // Redirect with two requests in flight and two groups buffered.
    do_reset();
    decode_ready = 1'b0;
    repeat (4) step();
    do_redirect(32'h100);
    decode_ready = 1'b1;
    repeat (12) step();

    // Redirect during handshake plus memory return; back-to-back redirects.
    do_redirect(32'h40);
    repeat (10) step();
    do_redirect(32'h200);
    do_redirect(32'h300);
    repeat (10) step();

    // PC wrap at the top of the address space.
    do_redirect(32'hFFFF_FFFC);
    repeat (10) step();

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_req",   {63'h0, imem_req},     64'h0);
    chk("async_valid", {63'h0, decode_valid}, 64'h0);
    chk("async_pc",    {32'h0, decode_pc},    64'h0);
    chk("async_data",  decode_data,           64'h0);
    step();
    step();
    flush_expect(RESET_PC);
    rst = 1'b0;
    repeat (15) step();

    // Short stall pattern exercising handshake/backpressure counting.
    decode_ready = 1'b0;
    repeat (3) step();
    decode_ready = 1'b1;
    repeat (5) step();

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      decode_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) < 3) do_redirect($urandom & 32'hFFFF_FFFE);
      else                           step();
    end

    decode_ready = 1'b1;
    repeat (10) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
